// File: rtl/weight_bank_writer_pkg.sv
// Shared constants for the weight bank writer: FSM encoding, default sizes, bank count.
package weight_bank_writer_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_DEPTH  = 16;
    localparam int NUM_BANKS  = 2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_FILL      = 2'd1;
    localparam logic [1:0] ST_WAIT_BANK = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

endpackage

// File: rtl/wbw_bank_ctrl.sv
// Per-bank occupancy tracker: full flag and word count, close takes priority over release.
module wbw_bank_ctrl #(
    parameter int CNT_BITS = 5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_close,
    input  logic [CNT_BITS-1:0] i_close_cnt,
    input  logic                i_rel,
    output logic                o_full,
    output logic [CNT_BITS-1:0] o_cnt
);

    logic                r_full;
    logic [CNT_BITS-1:0] r_cnt;

    // A release aimed at an empty bank falls through harmlessly; the count is kept for inspection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_cnt  <= '0;
        end else if (i_close) begin
            r_full <= 1'b1;
            r_cnt  <= i_close_cnt;
        end else if (i_rel) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/weight_bank_writer.sv
// Streams weight words into two ping-pong SRAM banks, closing a bank on fill or end of job.
module weight_bank_writer
    import weight_bank_writer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic [ADDR_W:0]                 i_bank_words,
    input  logic [CNT_W-1:0]                i_total_words,
    input  logic                            i_s_valid,
    input  logic [DATA_W-1:0]               i_s_data,
    output logic                            o_s_ready,
    input  logic [NUM_BANKS-1:0]            i_bank_rel,
    output logic [NUM_BANKS-1:0]            o_we,
    output logic [NUM_BANKS*ADDR_W-1:0]     o_addr,
    output logic [NUM_BANKS*DATA_W-1:0]     o_din,
    output logic [NUM_BANKS-1:0]            o_bank_full,
    output logic [NUM_BANKS*(ADDR_W+1)-1:0] o_bank_cnt,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err,
    output logic [1:0]                      o_state
);

    logic [1:0]        r_state;
    logic              r_sel;
    logic [ADDR_W-1:0] r_idx;
    logic [CNT_W-1:0]  r_rem;
    logic [ADDR_W:0]   r_bank_words;
    logic              r_err;

    logic                 w_idle_like;
    logic                 w_params_ok;
    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_last_job;
    logic                 w_close;
    logic                 w_other;
    logic [ADDR_W:0]      w_fill_cnt;
    logic [NUM_BANKS-1:0] w_close_vec;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_params_ok = (i_bank_words != '0) && (i_bank_words <= (ADDR_W+1)'(DEPTH))
                         && (i_total_words != '0);
    assign w_accept    = i_start && w_idle_like && w_params_ok;

    // Stream handshake: a word moves on any cycle where i_s_valid and o_s_ready are both high;
    // o_s_ready depends only on state and bank occupancy, never on i_s_valid.
    assign o_s_ready   = (r_state == ST_FILL) && !o_bank_full[r_sel];
    assign w_xfer      = i_s_valid && o_s_ready;
    assign w_fill_cnt  = (ADDR_W+1)'(r_idx) + (ADDR_W+1)'(1);
    assign w_last_job  = (r_rem == CNT_W'(1));
    assign w_close     = w_xfer && ((w_fill_cnt == r_bank_words) || w_last_job);
    assign w_other     = ~r_sel;
    assign w_close_vec = w_close ? (r_sel ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        o_we   = '0;
        o_addr = '0;
        o_din  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_xfer && (int'(r_sel) == b)) begin
                o_we[b]                      = 1'b1;
                o_addr[b*ADDR_W +: ADDR_W]   = r_idx;
                o_din[b*DATA_W +: DATA_W]    = i_s_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        wbw_bank_ctrl #(.CNT_BITS(ADDR_W+1)) u_ctrl (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_close     (w_close_vec[g]),
            .i_close_cnt (w_fill_cnt),
            .i_rel       (i_bank_rel[g]),
            .o_full      (o_bank_full[g]),
            .o_cnt       (o_bank_cnt[g*(ADDR_W+1) +: ADDR_W+1])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_sel        <= 1'b0;
            r_idx        <= '0;
            r_rem        <= '0;
            r_bank_words <= '0;
            r_err        <= 1'b0;
        end else begin
            if (i_start) begin
                r_err <= !w_accept;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_state      <= ST_FILL;
                        r_sel        <= 1'b0;
                        r_idx        <= '0;
                        r_rem        <= i_total_words;
                        r_bank_words <= i_bank_words;
                    end
                end
                ST_FILL: begin
                    if (w_xfer) begin
                        r_rem <= r_rem - CNT_W'(1);
                        if (w_close) begin
                            r_idx <= '0;
                            r_sel <= w_other;
                            // A release of the next bank in this very cycle frees it in time.
                            if (w_last_job) begin
                                r_state <= ST_DONE;
                            end else if (o_bank_full[w_other] && !i_bank_rel[w_other]) begin
                                r_state <= ST_WAIT_BANK;
                            end
                        end else begin
                            r_idx <= r_idx + ADDR_W'(1);
                        end
                    end
                end
                ST_WAIT_BANK: begin
                    if (!o_bank_full[r_sel] || i_bank_rel[r_sel]) begin
                        r_state <= ST_FILL;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy  = (r_state == ST_FILL) || (r_state == ST_WAIT_BANK);
    assign o_done  = (r_state == ST_DONE);
    assign o_err   = r_err;
    assign o_state = r_state;

endmodule

// File: tb/tb_weight_bank_writer.sv
// Randomized bench for weight_bank_writer against a word-index based reference model.
module tb_weight_bank_writer;
    import weight_bank_writer_pkg::*;

    localparam int DW = 64;
    localparam int AW = 4;
    localparam int CW = 16;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   bank_words;
    logic [CW-1:0] total_words;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [1:0]    bank_rel;
    logic [1:0]    we;
    logic [2*AW-1:0]   addr;
    logic [2*DW-1:0]   din;
    logic [1:0]        bank_full;
    logic [2*(AW+1)-1:0] bank_cnt;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    state;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_full[2];
    int          m_cnt[2];
    logic [DW-1:0] exp_q[$];

    weight_bank_writer #(.DATA_W(DW), .DEPTH(16), .CNT_W(CW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_bank_words  (bank_words),
        .i_total_words (total_words),
        .i_s_valid     (s_valid),
        .i_s_data      (s_data),
        .o_s_ready     (s_ready),
        .i_bank_rel    (bank_rel),
        .o_we          (we),
        .o_addr        (addr),
        .o_din         (din),
        .o_bank_full   (bank_full),
        .o_bank_cnt    (bank_cnt),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .o_state       (state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_state"}, state, ST_IDLE);
        check_val({tag, "_ready"}, s_ready, 0);
        check_val({tag, "_we"}, we, 0);
        check_val({tag, "_addr"}, addr, 0);
        check_val({tag, "_din"}, din, 0);
        check_val({tag, "_full"}, bank_full, 0);
        check_val({tag, "_cnt"}, bank_cnt, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_err"}, err, 0);
    endtask

    task automatic release_all();
        bank_rel = 2'b11;
        @(posedge clk); #1;
        bank_rel = 2'b00;
        m_full[0] = 0;
        m_full[1] = 0;
        @(negedge clk);
        check_val("rel_clear", bank_full, 0);
        @(posedge clk); #1;
    endtask

    task automatic bad_start(input int bw, input int tw, input logic [1:0] exp_state);
        bank_words  = 5'(bw);
        total_words = 16'(tw);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_val("bad_start_err", err, 1);
        check_val("bad_start_busy", busy, 0);
        check_val("bad_start_state", state, exp_state);
        @(posedge clk); #1;
    endtask

    // Word k of a job lands in fill k/bw, bank (k/bw)%2, address k%bw.
    // mode: 0 no releases, 1 random releases, 2 release a needed bank after a stall, 3 release on close.
    task automatic run_job(input int bw, input int tw, input int gap, input int mode, input bit inj);
        int k;
        int cyc;
        int b;
        int stall;
        bit exp_ready;
        bit xfer;
        bit closing;
        logic [DW-1:0] word;
        k = 0;
        cyc = 0;
        stall = 0;
        exp_q.delete();
        bank_words  = 5'(bw);
        total_words = 16'(tw);
        s_valid  = 1'b0;
        bank_rel = 2'b00;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        word = {$urandom, $urandom};
        exp_q.push_back(word);
        while (k < tw && cyc < BUDGET) begin
            b = (k / bw) % 2;
            exp_ready = !m_full[b];
            s_valid = ($urandom_range(99) >= gap);
            s_data  = word;
            xfer    = s_valid && exp_ready;
            closing = xfer && ((((k + 1) % bw) == 0) || (k + 1 == tw));
            bank_rel = 2'b00;
            case (mode)
                1: begin
                    bank_rel[0] = ($urandom_range(3) == 0);
                    bank_rel[1] = ($urandom_range(3) == 0);
                end
                2: begin
                    if (m_full[b]) begin
                        stall++;
                        if (stall >= 3) begin
                            bank_rel[b] = 1'b1;
                            stall = 0;
                        end
                    end
                end
                3: if (closing) bank_rel[b] = 1'b1;
                default: ;
            endcase
            start = inj && (cyc == 2);
            @(negedge clk);
            check_val("busy", busy, 1);
            check_val("s_ready", s_ready, exp_ready);
            check_val("we", we, xfer ? (2'b01 << b) : 2'b00);
            if (mode == 2 && stall == 2) check_val("state_wait", state, ST_WAIT_BANK);
            if (xfer) begin
                check_val("addr", addr[b*AW +: AW], k % bw);
                check_val("din_order", din[b*DW +: DW], exp_q.pop_front());
            end
            for (int i = 0; i < 2; i++) if (bank_rel[i]) m_full[i] = 0;
            if (closing) begin
                m_full[b] = 1;
                m_cnt[b]  = (k % bw) + 1;
            end
            if (xfer) begin
                k++;
                word = {$urandom, $urandom};
                exp_q.push_back(word);
            end
            cyc++;
            @(posedge clk); #1;
        end
        s_valid  = 1'b0;
        bank_rel = 2'b00;
        start    = 1'b0;
        if (cyc >= BUDGET) check_val("job_timeout", cyc, 0);
        @(negedge clk);
        check_val("done", done, 1);
        check_val("busy_end", busy, 0);
        check_val("err", err, inj);
        check_val("bank_full", bank_full, {m_full[1], m_full[0]});
        for (int i = 0; i < 2; i++) begin
            if (m_full[i]) check_val("bank_cnt", bank_cnt[i*(AW+1) +: AW+1], m_cnt[i]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bank_words = '0;
        total_words = '0;
        s_valid = 1'b0;
        s_data = '0;
        bank_rel = 2'b00;
        m_full[0] = 0;
        m_full[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        bad_start(0, 8, ST_IDLE);
        bad_start(17, 8, ST_IDLE);
        bad_start(4, 0, ST_IDLE);

        run_job(4, 8, 0, 0, 0);
        check_val("two_full", bank_full, 2'b11);
        check_val("cnt_4_4", bank_cnt, {5'd4, 5'd4});
        bad_start(0, 5, ST_DONE);
        release_all();

        run_job(4, 12, 0, 2, 0);
        release_all();

        run_job(16, 5, 0, 0, 0);
        check_val("cnt0_5", bank_cnt[AW:0], 5);
        release_all();

        run_job(4, 4, 0, 3, 0);
        check_val("set_wins", bank_full[0], 1);
        release_all();

        run_job(3, 7, 40, 1, 0);
        release_all();

        run_job(4, 8, 20, 1, 1);
        release_all();

        for (int j = 0; j < 4; j++) begin
            run_job($urandom_range(1, 16), $urandom_range(1, 40), $urandom_range(0, 50), 1, 0);
            release_all();
        end

        // Abandon a job after the first bank has closed.
        bank_words = 5'd4;
        total_words = 16'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b1;
        s_data = {$urandom, $urandom};
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check_val("pre_rst_full", bank_full[0], 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_outputs("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("post_rst_we", we, 0);
            check_val("post_rst_ready", s_ready, 0);
        end
        s_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
